riscv_core_branch_target_buffer: RTL and testbench
==================================================

Name: riscv_core_branch_target_buffer

Overview:
Branch target buffer (BTB) with 2-bit saturating direction counters. It supplies the fetch-stage prediction: valid/hit, predicted-taken and predicted target. These feed the EX-stage misprediction recovery logic. The block trains its entries from the resolved branch/jump outcome returned by EX, closing the predict/resolve loop.

Parameters:
ALEN, 64, address width.
ENTRIES, 16, number of direct-mapped entries; power of two, at least 2.
IDXW, 4, index width; must equal log2(ENTRIES).
TAGW, 20, stored tag width; tag = pc[2+IDXW+TAGW-1 : 2+IDXW].

Ports:
i_clk  input  1  clock, rising edge.
i_rst_n  input  1  asynchronous active-low reset.
i_flush  input  1  synchronous invalidate of all entries.
i_lookup_pc  input  ALEN  fetch PC.
o_valid  output  1  lookup hit.
o_taken  output  1  predicted taken.
o_target  output  ALEN  predicted target; 0 when no hit.
i_upd_valid  input  1  EX resolution strobe, one update per cycle.
i_upd_pc  input  ALEN  PC of the resolved instruction.
i_upd_branch  input  1  resolved instruction is a conditional branch.
i_upd_jump  input  1  resolved instruction is JAL/JALR.
i_upd_taken  input  1  actual outcome.
i_upd_target  input  ALEN  actual target address.

Behaviour:
- Index = pc[2+IDXW-1:2]; PC bits [1:0] are ignored (no compressed ISA).
- Each entry holds: valid, is_jump, tag[TAGW], target[ALEN] and cnt[2].
- Reset (i_rst_n low, asynchronous):
  - all valid=0, is_jump=0, cnt=2'b01, target=0, tag=0;
  - outputs go to o_valid=0, o_taken=0, o_target=0 combinationally.
- Lookup is combinational, with zero-cycle latency:
  - hit = entry.valid & (entry.tag == lookup tag);
  - o_valid = hit;
  - o_taken = hit & (is_jump | cnt[1]);
  - o_target = hit ? target : 0.
- Update, applied at the rising edge when i_upd_valid=1:
  - jump (i_upd_jump=1): write entry with valid=1, is_jump=1, tag, target=i_upd_target and cnt=2'b11, regardless of hit.
  - branch, taken, hit: cnt saturating increment (stays 11 at 11); target overwritten; is_jump=0.
  - branch, taken, miss: allocate the entry, replacing any occupant, with valid=1, is_jump=0, cnt=2'b10, tag and target.
  - branch, not taken, hit: cnt saturating decrement (stays 00 at 00); the entry stays valid and target is unchanged.
  - branch, not taken, miss: no change.
  - i_upd_branch=i_upd_jump=0, or both 1: no change. Both-high is illegal; the bench asserts it never occurs.
- i_flush=1 at the edge clears all valid bits; cnt, target and tag are untouched.
- Flush and update in the same cycle: flush wins and the update is dropped.
- Lookup and update to the same index in the same cycle: the lookup returns the pre-update contents. The new contents are visible from the next cycle.
- Reset asserted mid-operation: state clears immediately. No update is applied on the edge where i_rst_n is low.
- Aliasing: PCs sharing index and tag hit the same entry; this is accepted behaviour.

Optional Feature:
Macro: BTB_STATS_EN.
- Defined: adds three outputs, each 32 bits, wrapping at 2^32-1 to 0, all reset to 0 and cleared by neither flush nor anything except reset.
  - o_stat_lookups: counts every cycle.
  - o_stat_hits: counts cycles with hit=1.
  - o_stat_updates: counts accepted updates, meaning i_upd_valid with exactly one of branch/jump set and no flush.
- Undefined: these ports and counters do not exist; the rest of the behaviour is identical.

Test Plan:
- After reset, lookup 0x1000 -> o_valid=0, o_taken=0, o_target=0.
- Update branch taken, pc=0x1000, target=0x2000 -> next cycle, lookup 0x1000 gives o_valid=1, o_taken=1 (cnt=10), o_target=0x2000.
- Two not-taken updates on 0x1000 -> cnt goes 10, then 01, then 00; o_valid=1, o_taken=0. A third not-taken keeps cnt=00. Two taken updates -> cnt 01, then 10, so o_taken=1.
- Jump update pc=0x1040, target=0x3000, with a same-cycle lookup of 0x1040 -> the same cycle gives o_valid=0; the next cycle gives o_valid=1, o_taken=1, o_target=0x3000.
- Alias test: pc=0x1000 and pc=0x1000+(1<<6) share index 0 with different tags.
  - Allocate the second PC -> lookup 0x1000 misses.
  - Not-taken update on a miss -> no allocation.
- i_flush together with a jump update at 0x1080 -> every lookup misses afterwards, including 0x1080. With BTB_STATS_EN, the update counter is unchanged; the lookup counter equals the cycles since reset.

Source files
------------

// File: rtl/riscv_core_branch_target_buffer.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Optional BTB_STATS_EN macro adds lookup/hit/update statistics counters.
module riscv_core_branch_target_buffer #(
    parameter int ALEN    = 64,
    parameter int ENTRIES = 16,
    parameter int IDXW    = 4,
    parameter int TAGW    = 20
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_flush,
    input  logic [ALEN-1:0] i_lookup_pc,
    output logic            o_valid,
    output logic            o_taken,
    output logic [ALEN-1:0] o_target,
    input  logic            i_upd_valid,
    input  logic [ALEN-1:0] i_upd_pc,
    input  logic            i_upd_branch,
    input  logic            i_upd_jump,
    input  logic            i_upd_taken,
    input  logic [ALEN-1:0] i_upd_target
`ifdef BTB_STATS_EN
    ,
    output logic [31:0]     o_stat_lookups,
    output logic [31:0]     o_stat_hits,
    output logic [31:0]     o_stat_updates
`endif
);

    localparam int TLO = 2 + IDXW;
    localparam int THI = 2 + IDXW + TAGW - 1;

    logic            valid_q   [ENTRIES];
    logic            is_jump_q [ENTRIES];
    logic [TAGW-1:0] tag_q     [ENTRIES];
    logic [ALEN-1:0] target_q  [ENTRIES];
    logic [1:0]      cnt_q     [ENTRIES];

    logic [IDXW-1:0] lk_idx;
    logic [TAGW-1:0] lk_tag;
    logic            lk_hit;
    logic [IDXW-1:0] up_idx;
    logic [TAGW-1:0] up_tag;
    logic            up_hit;

    logic            we_d;
    logic            valid_d;
    logic            is_jump_d;
    logic [TAGW-1:0] tag_d;
    logic [ALEN-1:0] target_d;
    logic [1:0]      cnt_d;

    // PC bits outside index/tag never take part in matching
    logic unused_pc_bits;
    assign unused_pc_bits = ^{i_lookup_pc[1:0], i_lookup_pc[ALEN-1:THI+1],
                              i_upd_pc[1:0], i_upd_pc[ALEN-1:THI+1]};

    assign lk_idx = i_lookup_pc[TLO-1:2];
    assign lk_tag = i_lookup_pc[THI:TLO];
    assign up_idx = i_upd_pc[TLO-1:2];
    assign up_tag = i_upd_pc[THI:TLO];

    // Combinational lookup against the current (pre-update) entry
    always_comb begin
        lk_hit   = valid_q[lk_idx] & (tag_q[lk_idx] == lk_tag);
        up_hit   = valid_q[up_idx] & (tag_q[up_idx] == up_tag);
        o_valid  = lk_hit;
        o_taken  = lk_hit & (is_jump_q[lk_idx] | cnt_q[lk_idx][1]);
        o_target = lk_hit ? target_q[lk_idx] : '0;
    end

    // Next contents of the entry addressed by the resolved instruction
    always_comb begin
        we_d      = 1'b0;
        valid_d   = valid_q[up_idx];
        is_jump_d = is_jump_q[up_idx];
        tag_d     = tag_q[up_idx];
        target_d  = target_q[up_idx];
        cnt_d     = cnt_q[up_idx];
        if (i_upd_valid && !i_flush) begin
            if (i_upd_jump && !i_upd_branch) begin
                we_d      = 1'b1;
                valid_d   = 1'b1;
                is_jump_d = 1'b1;
                tag_d     = up_tag;
                target_d  = i_upd_target;
                cnt_d     = 2'b11;
            end else if (i_upd_branch && !i_upd_jump) begin
                if (i_upd_taken) begin
                    we_d      = 1'b1;
                    valid_d   = 1'b1;
                    is_jump_d = 1'b0;
                    tag_d     = up_tag;
                    target_d  = i_upd_target;
                    if (up_hit) begin
                        cnt_d = (cnt_q[up_idx] == 2'b11) ? 2'b11
                                                         : cnt_q[up_idx] + 2'b01;
                    end else begin
                        cnt_d = 2'b10;
                    end
                end else if (up_hit) begin
                    we_d  = 1'b1;
                    cnt_d = (cnt_q[up_idx] == 2'b00) ? 2'b00
                                                     : cnt_q[up_idx] - 2'b01;
                end
            end
        end
    end

    // Entry storage: async reset, flush clears valid only, else one write
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]   <= 1'b0;
                is_jump_q[i] <= 1'b0;
                tag_q[i]     <= '0;
                target_q[i]  <= '0;
                cnt_q[i]     <= 2'b01;
            end
        end else if (i_flush) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
            end
        end else if (we_d) begin
            valid_q[up_idx]   <= valid_d;
            is_jump_q[up_idx] <= is_jump_d;
            tag_q[up_idx]     <= tag_d;
            target_q[up_idx]  <= target_d;
            cnt_q[up_idx]     <= cnt_d;
        end
    end

`ifdef BTB_STATS_EN
    logic [31:0] lookups_q, lookups_d;
    logic [31:0] hits_q, hits_d;
    logic [31:0] updates_q, updates_d;
    logic        upd_acc;

    assign upd_acc = i_upd_valid & (i_upd_branch ^ i_upd_jump) & ~i_flush;

    // Free-running wrap-around statistics
    always_comb begin
        lookups_d = lookups_q + 32'd1;
        hits_d    = hits_q + {31'd0, lk_hit};
        updates_d = updates_q + {31'd0, upd_acc};
    end

    // Statistics registers, cleared only by reset
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            lookups_q <= '0;
            hits_q    <= '0;
            updates_q <= '0;
        end else begin
            lookups_q <= lookups_d;
            hits_q    <= hits_d;
            updates_q <= updates_d;
        end
    end

    assign o_stat_lookups = lookups_q;
    assign o_stat_hits    = hits_q;
    assign o_stat_updates = updates_q;
`endif

endmodule

// File: tb/tb_riscv_core_branch_target_buffer.sv
// Directed bench for riscv_core_branch_target_buffer.
// Build with BTB_STATS_EN defined to also exercise the statistics counters.
module tb_riscv_core_branch_target_buffer;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_flush;
    logic [63:0] i_lookup_pc;
    logic        o_valid;
    logic        o_taken;
    logic [63:0] o_target;
    logic        i_upd_valid;
    logic [63:0] i_upd_pc;
    logic        i_upd_branch;
    logic        i_upd_jump;
    logic        i_upd_taken;
    logic [63:0] i_upd_target;
`ifdef BTB_STATS_EN
    logic [31:0] o_stat_lookups;
    logic [31:0] o_stat_hits;
    logic [31:0] o_stat_updates;
`endif

    int checks = 0;
    int passed = 0;
    int cyc    = 0;

    riscv_core_branch_target_buffer dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_flush      (i_flush),
        .i_lookup_pc  (i_lookup_pc),
        .o_valid      (o_valid),
        .o_taken      (o_taken),
        .o_target     (o_target),
        .i_upd_valid  (i_upd_valid),
        .i_upd_pc     (i_upd_pc),
        .i_upd_branch (i_upd_branch),
        .i_upd_jump   (i_upd_jump),
        .i_upd_taken  (i_upd_taken),
        .i_upd_target (i_upd_target)
`ifdef BTB_STATS_EN
        ,
        .o_stat_lookups (o_stat_lookups),
        .o_stat_hits    (o_stat_hits),
        .o_stat_updates (o_stat_updates)
`endif
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    always @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    always @(posedge i_clk) begin
        assert (!(i_upd_valid && i_upd_branch && i_upd_jump))
        else $error("FAIL both_high: branch and jump asserted together");
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic look(input string tag, input logic [63:0] pc,
                        input logic v, input logic t,
                        input logic [63:0] tgt);
        i_lookup_pc = pc;
        #1;
        chk({tag, "_valid"}, {63'd0, o_valid}, {63'd0, v});
        chk({tag, "_taken"}, {63'd0, o_taken}, {63'd0, t});
        chk({tag, "_target"}, o_target, tgt);
    endtask

    // Apply one update across a rising edge, returning at the next negedge
    task automatic upd(input logic [63:0] pc, input logic br,
                       input logic jp, input logic tk,
                       input logic [63:0] tgt);
        i_upd_valid  = 1'b1;
        i_upd_pc     = pc;
        i_upd_branch = br;
        i_upd_jump   = jp;
        i_upd_taken  = tk;
        i_upd_target = tgt;
        @(negedge i_clk);
        i_upd_valid  = 1'b0;
        i_upd_branch = 1'b0;
        i_upd_jump   = 1'b0;
    endtask

    initial begin
        i_rst_n      = 1'b0;
        i_flush      = 1'b0;
        i_lookup_pc  = 64'h1000;
        i_upd_valid  = 1'b0;
        i_upd_pc     = '0;
        i_upd_branch = 1'b0;
        i_upd_jump   = 1'b0;
        i_upd_taken  = 1'b0;
        i_upd_target = '0;

        #12;
        look("in_reset", 64'h1000, 1'b0, 1'b0, 64'h0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        look("post_reset", 64'h1000, 1'b0, 1'b0, 64'h0);

        // allocate taken branch, cnt=10
        upd(64'h1000, 1'b1, 1'b0, 1'b1, 64'h2000);
        look("alloc", 64'h1000, 1'b1, 1'b1, 64'h2000);
        // 10 -> 01 -> 00 -> 00
        upd(64'h1000, 1'b1, 1'b0, 1'b0, 64'h0);
        look("nt1", 64'h1000, 1'b1, 1'b0, 64'h2000);
        upd(64'h1000, 1'b1, 1'b0, 1'b0, 64'h0);
        look("nt2", 64'h1000, 1'b1, 1'b0, 64'h2000);
        upd(64'h1000, 1'b1, 1'b0, 1'b0, 64'h0);
        look("nt3_sat", 64'h1000, 1'b1, 1'b0, 64'h2000);
        // 00 -> 01 -> 10
        upd(64'h1000, 1'b1, 1'b0, 1'b1, 64'h2000);
        look("t1", 64'h1000, 1'b1, 1'b0, 64'h2000);
        upd(64'h1000, 1'b1, 1'b0, 1'b1, 64'h2000);
        look("t2", 64'h1000, 1'b1, 1'b1, 64'h2000);
        // 10 -> 11 with new target, 11 stays 11
        upd(64'h1000, 1'b1, 1'b0, 1'b1, 64'h2400);
        look("t3_tgt", 64'h1000, 1'b1, 1'b1, 64'h2400);
        upd(64'h1000, 1'b1, 1'b0, 1'b1, 64'h2400);
        look("t4_sat", 64'h1000, 1'b1, 1'b1, 64'h2400);
        // 11 -> 10 -> 01
        upd(64'h1000, 1'b1, 1'b0, 1'b0, 64'h0);
        look("nt4", 64'h1000, 1'b1, 1'b1, 64'h2400);
        upd(64'h1000, 1'b1, 1'b0, 1'b0, 64'h0);
        look("nt5", 64'h1000, 1'b1, 1'b0, 64'h2400);

        // jump at aliasing PC 0x1040 with same-cycle lookup
        i_lookup_pc  = 64'h1040;
        i_upd_valid  = 1'b1;
        i_upd_pc     = 64'h1040;
        i_upd_branch = 1'b0;
        i_upd_jump   = 1'b1;
        i_upd_taken  = 1'b1;
        i_upd_target = 64'h3000;
        look("jmp_same", 64'h1040, 1'b0, 1'b0, 64'h0);
        @(negedge i_clk);
        i_upd_valid = 1'b0;
        i_upd_jump  = 1'b0;
        look("jmp_next", 64'h1040, 1'b1, 1'b1, 64'h3000);
        look("alias_miss", 64'h1000, 1'b0, 1'b0, 64'h0);

        // not-taken miss allocates nothing
        upd(64'h1104, 1'b1, 1'b0, 1'b0, 64'h5000);
        look("nt_miss", 64'h1104, 1'b0, 1'b0, 64'h0);
        upd(64'h1000, 1'b1, 1'b0, 1'b0, 64'h5000);
        look("nt_alias", 64'h1040, 1'b1, 1'b1, 64'h3000);
        // neither branch nor jump: ignored
        upd(64'h1108, 1'b0, 1'b0, 1'b1, 64'h6000);
        look("neither", 64'h1108, 1'b0, 1'b0, 64'h0);

        // flush wins over same-cycle jump update
        i_flush = 1'b1;
        upd(64'h1080, 1'b0, 1'b1, 1'b1, 64'h4000);
        i_flush = 1'b0;
        look("flush_1080", 64'h1080, 1'b0, 1'b0, 64'h0);
        look("flush_1040", 64'h1040, 1'b0, 1'b0, 64'h0);
`ifdef BTB_STATS_EN
        chk("stat_updates", {32'd0, o_stat_updates}, 64'd13);
        chk("stat_lookups", {32'd0, o_stat_lookups}, 64'(cyc));
`endif

        // async reset mid-operation, update on the reset edge dropped
        upd(64'h1104, 1'b0, 1'b1, 1'b1, 64'h7000);
        look("pre_rst", 64'h1104, 1'b1, 1'b1, 64'h7000);
        i_upd_valid  = 1'b1;
        i_upd_pc     = 64'h1108;
        i_upd_jump   = 1'b1;
        i_upd_target = 64'h8000;
        i_rst_n      = 1'b0;
        look("mid_rst", 64'h1104, 1'b0, 1'b0, 64'h0);
        @(negedge i_clk);
        i_upd_valid = 1'b0;
        i_upd_jump  = 1'b0;
        i_rst_n     = 1'b1;
        look("rst_drop", 64'h1108, 1'b0, 1'b0, 64'h0);
        look("rst_clear", 64'h1104, 1'b0, 1'b0, 64'h0);
`ifdef BTB_STATS_EN
        chk("stat_rst_upd", {32'd0, o_stat_updates}, 64'd0);
        chk("stat_rst_lk", {32'd0, o_stat_lookups}, 64'd0);
        chk("stat_rst_hit", {32'd0, o_stat_hits}, 64'd0);
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
